// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data request ports and memory-controller bus of mem_arbiter.
// Handshake: a requester raises *_req with its fields stable and holds them until
// its one-cycle *_valid pulse; the arbiter raises m_req with the m_* fields stable
// and holds it until the cycle in which m_ack is high (m_rdata valid in that cycle).
// The slave modport is the arbiter's view (it serves requests and drives memory);
// the master modport is the surrounding pipeline plus memory controller.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_ack, m_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, d_err,
    output m_req, m_we, m_addr, m_wdata, m_be
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_size, d_addr, d_wdata, m_ack, m_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, d_err,
    input  m_req, m_we, m_addr, m_wdata, m_be
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and the data stage.
// Data has priority, bounded by a streak counter so a waiting fetch is not starved.
// Data accesses become word transactions with byte enables; loads come back
// right-aligned; misaligned data accesses complete at once with d_err.
module mem_arbiter #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus,
  output logic [1:0]   o_state
);
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, RESP = 2'd2} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [SW-1:0] r_streak;
  logic        w_streak_full;
  logic        w_grant_d;
  logic        w_grant_f;
  logic        w_misalign;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_shifted;
  logic [31:0] w_load;
  logic        r_m_req;
  logic        r_m_we;
  logic [31:0] r_m_addr;
  logic [31:0] r_m_wdata;
  logic [3:0]  r_m_be;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_if_valid;
  logic        r_d_valid;
  logic        r_d_err;
  logic        r_fetch;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        w_unused_ok;

  // Fetch addresses are word aligned by contract, so their low bits carry nothing.
  assign w_unused_ok   = &{1'b0, bus.if_addr[1:0]};
  assign w_streak_full = (r_streak == SW'(MAX_D_STREAK));

  // Decode the data access: effective size, alignment, lane enables, replicated store data.
  always_comb begin
    w_size     = (bus.d_size == 2'd3) ? 2'd2 : bus.d_size;
    w_misalign = 1'b0;
    w_be       = 4'hF;
    w_wdata    = bus.d_wdata;
    case (w_size)
      2'd0: begin
        w_be    = 4'b0001 << bus.d_addr[1:0];
        w_wdata = {4{bus.d_wdata[7:0]}};
      end
      2'd1: begin
        w_misalign = bus.d_addr[0];
        w_be       = 4'b0011 << {bus.d_addr[1], 1'b0};
        w_wdata    = {2{bus.d_wdata[15:0]}};
      end
      default: w_misalign = (bus.d_addr[1:0] != 2'b00);
    endcase
  end

  // Next state and grant decision; the grant only happens in IDLE.
  always_comb begin
    w_next    = r_state;
    w_grant_d = 1'b0;
    w_grant_f = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && w_streak_full)) w_grant_d = 1'b1;
        else if (bus.if_req)                             w_grant_f = 1'b1;
        if (w_grant_d && w_misalign)     w_next = RESP;
        else if (w_grant_d || w_grant_f) w_next = ACC;
      end
      ACC:     if (bus.m_ack) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Right-align the returned word by the latched byte offset, then trim to size.
  always_comb begin
    w_shifted = bus.m_rdata >> {r_off, 3'b000};
    w_load    = w_shifted;
    case (r_size)
      2'd0:    w_load = {24'h0, w_shifted[7:0]};
      2'd1:    w_load = {16'h0, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Data-grant streak: counts data wins while fetch waits, cleared once fetch stops waiting or wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_streak <= '0;
    else if (!bus.if_req || w_grant_f) r_streak <= '0;
    else if (w_grant_d)                r_streak <= r_streak + 1'b1;
  end

  // Registered datapath: latch the granted access, drive memory, capture and pulse results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= 32'h0;
      r_m_wdata  <= 32'h0;
      r_m_be     <= 4'h0;
      r_if_rdata <= 32'h0;
      r_d_rdata  <= 32'h0;
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
      r_fetch    <= 1'b0;
      r_off      <= 2'b00;
      r_size     <= 2'b00;
    end else begin
      r_if_valid <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_fetch <= 1'b0;
            r_off   <= bus.d_addr[1:0];
            r_size  <= w_size;
            if (w_misalign) begin
              r_d_valid <= 1'b1;
              r_d_err   <= 1'b1;
              r_d_rdata <= 32'h0;
            end else begin
              r_m_req   <= 1'b1;
              r_m_we    <= bus.d_we;
              r_m_addr  <= {bus.d_addr[31:2], 2'b00};
              r_m_be    <= w_be;
              r_m_wdata <= w_wdata;
            end
          end else if (w_grant_f) begin
            r_fetch   <= 1'b1;
            r_off     <= 2'b00;
            r_size    <= 2'd2;
            r_m_req   <= 1'b1;
            r_m_we    <= 1'b0;
            r_m_addr  <= {bus.if_addr[31:2], 2'b00};
            r_m_be    <= 4'hF;
            r_m_wdata <= 32'h0;
          end
        end
        ACC: begin
          if (bus.m_ack) begin
            r_m_req <= 1'b0;
            if (r_fetch) begin
              r_if_valid <= 1'b1;
              r_if_rdata <= bus.m_rdata;
            end else begin
              r_d_valid <= 1'b1;
              r_d_rdata <= r_m_we ? 32'h0 : w_load;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.m_req    = r_m_req;
  assign bus.m_we     = r_m_we;
  assign bus.m_addr   = r_m_addr;
  assign bus.m_wdata  = r_m_wdata;
  assign bus.m_be     = r_m_be;
  assign bus.if_rdata = r_if_rdata;
  assign bus.if_valid = r_if_valid;
  assign bus.d_rdata  = r_d_rdata;
  assign bus.d_valid  = r_d_valid;
  assign bus.d_err    = r_d_err;
  assign o_state      = r_state;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a byte-level
// memory reference model, with a memory responder of programmable ack delay.
module tb_mem_arbiter;
  localparam int MAXS = 4;
  localparam logic [31:0] FA = 32'h80;
  localparam logic [31:0] DA = 32'h40;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;
  int          checks;
  int          failures;
  int          ack_dly;
  int          ack_cnt;
  int          model_cnt;
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_D_STREAK(MAXS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .o_state (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Memory device: acks the ack_dly-th cycle of m_req, applies write lanes on ack.
  always @(negedge clk) begin
    if (bus.m_req && rst_n) begin
      ack_cnt = ack_cnt + 1;
      if (ack_cnt == ack_dly) begin
        bus.m_ack   = 1'b1;
        bus.m_rdata = mem[bus.m_addr[9:2]];
        if (bus.m_we)
          for (int i = 0; i < 4; i++)
            if (bus.m_be[i]) mem[bus.m_addr[9:2]][8*i +: 8] = bus.m_wdata[8*i +: 8];
      end else begin
        bus.m_ack   = 1'b0;
        bus.m_rdata = $urandom;
      end
    end else begin
      ack_cnt     = 0;
      bus.m_ack   = 1'b0;
      bus.m_rdata = $urandom;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_m_req"},    32'(bus.m_req),    32'h0);
    check({tag, "_m_we"},     32'(bus.m_we),     32'h0);
    check({tag, "_m_addr"},   bus.m_addr,        32'h0);
    check({tag, "_m_wdata"},  bus.m_wdata,       32'h0);
    check({tag, "_m_be"},     32'(bus.m_be),     32'h0);
    check({tag, "_if_rdata"}, bus.if_rdata,      32'h0);
    check({tag, "_d_rdata"},  bus.d_rdata,       32'h0);
    check({tag, "_if_valid"}, 32'(bus.if_valid), 32'h0);
    check({tag, "_d_valid"},  32'(bus.d_valid),  32'h0);
    check({tag, "_d_err"},    32'(bus.d_err),    32'h0);
    check({tag, "_state"},    32'(dbg_state),    32'h0);
  endtask

  // One data access from an idle arbiter; k = cycle of m_req in which memory acks.
  task automatic do_data(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, input int k);
    int nb, n, off, idx;
    logic mis, got, saw;
    logic [3:0]  ebe;
    logic [31:0] ewd, erd, mask;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off  = int'(addr[1:0]);
    idx  = int'(addr[9:2]);
    mis  = (addr % nb) != 0;
    ebe  = 4'(((1 << nb) - 1) << off);
    ewd  = (nb == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
           (nb == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
    mask = (nb == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * nb)) - 64'd1);
    erd  = (we || mis) ? 32'h0 : ((ref_mem[idx] >> (8 * off)) & mask);
    ack_dly     = k;
    bus.d_we    = we;
    bus.d_size  = size;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    bus.d_req   = 1'b1;
    n = 0; got = 1'b0; saw = 1'b0;
    while (!got && n < 30) begin
      @(posedge clk); #1; n++;
      if (bus.m_req && !saw) begin
        saw = 1'b1;
        check("d_mreq_lat", 32'(n), 32'd1);
        check("d_m_addr", bus.m_addr, addr & 32'hFFFF_FFFC);
        check("d_m_be", 32'(bus.m_be), 32'(ebe));
        check("d_m_we", 32'(bus.m_we), 32'(we));
        if (we) check("d_m_wdata", bus.m_wdata, ewd);
      end
      got = bus.d_valid;
    end
    check("d_valid_lat", 32'(n), mis ? 32'd1 : 32'(k + 1));
    check("d_err", 32'(bus.d_err), 32'(mis));
    check("d_rdata", bus.d_rdata, erd);
    check("d_mem_used", 32'(saw), 32'(!mis));
    check("d_if_quiet", 32'(bus.if_valid), 32'h0);
    bus.d_req = 1'b0;
    if (we && !mis)
      for (int i = 0; i < nb; i++) ref_mem[idx][8*(off+i) +: 8] = wdata[8*i +: 8];
    @(posedge clk); #1;
  endtask

  // One fetch from an idle arbiter; drop releases if_req once the memory access starts.
  task automatic do_fetch(input logic [31:0] addr, input int k, input logic drop);
    int n;
    logic got, saw;
    logic [31:0] exp;
    exp = ref_mem[addr[9:2]];
    ack_dly     = k;
    bus.if_addr = addr;
    bus.if_req  = 1'b1;
    n = 0; got = 1'b0; saw = 1'b0;
    while (!got && n < 30) begin
      @(posedge clk); #1; n++;
      if (bus.m_req && !saw) begin
        saw = 1'b1;
        check("f_mreq_lat", 32'(n), 32'd1);
        check("f_m_addr", bus.m_addr, addr);
        check("f_m_be", 32'(bus.m_be), 32'hF);
        check("f_m_we", 32'(bus.m_we), 32'h0);
        if (drop) bus.if_req = 1'b0;
      end
      got = bus.if_valid;
    end
    check("f_valid_lat", 32'(n), 32'(k + 1));
    check("f_rdata", bus.if_rdata, exp);
    check("f_d_quiet", 32'(bus.d_valid), 32'h0);
    bus.if_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Both requesters held: every grant alternates by the streak rule, k-cycle acks.
  task automatic collect(input int nwant, input int k);
    int nv, cyc, last;
    logic exp_f;
    nv = 0; cyc = 0; last = 0;
    while (nv < nwant && cyc < 400) begin
      @(posedge clk); #1; cyc++;
      if (bus.if_valid || bus.d_valid) begin
        exp_f     = (model_cnt == MAXS);
        model_cnt = exp_f ? 0 : model_cnt + 1;
        check("grant_order", 32'(bus.if_valid), 32'(exp_f));
        check("single_valid", 32'(bus.if_valid & bus.d_valid), 32'h0);
        check("valid_timing", 32'(cyc - last), (nv == 0) ? 32'(k + 1) : 32'(k + 2));
        if (exp_f) check("s_if_rdata", bus.if_rdata, ref_mem[FA[9:2]]);
        else       check("s_d_rdata", bus.d_rdata, ref_mem[DA[9:2]]);
        last = cyc;
        nv++;
      end
    end
    check("collect_count", 32'(nv), 32'(nwant));
  endtask

  initial begin
    int n;
    checks      = 0;
    failures    = 0;
    ack_dly     = 1;
    ack_cnt     = 0;
    model_cnt   = 0;
    rst_n       = 1'b0;
    bus.if_req  = 1'b0;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_size  = 2'd0;
    bus.d_addr  = 32'h0;
    bus.d_wdata = 32'h0;
    bus.m_ack   = 1'b0;
    bus.m_rdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[32'h100 >> 2]     = 32'h0050_0093;
    ref_mem[32'h100 >> 2] = 32'h0050_0093;

    #3 check_zero("reset");
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_fetch(32'h100, 1, 1'b0);
    do_data(1'b1, 2'd0, 32'h203, 32'h0000_00AB, 1);
    mem[32'h200 >> 2]     = 32'h8001_1234;
    ref_mem[32'h200 >> 2] = 32'h8001_1234;
    do_data(1'b0, 2'd1, 32'h202, 32'h0, 1);
    check("lh_value", bus.d_rdata, 32'h0000_8001);
    do_data(1'b0, 2'd0, 32'h201, 32'h0, 2);
    check("lbu_value", bus.d_rdata, 32'h0000_0012);
    do_data(1'b0, 2'd2, 32'h206, 32'h0, 1);
    do_data(1'b1, 2'd1, 32'h20A, 32'hDEAD_BEEF, 2);
    do_data(1'b1, 2'd3, 32'h20C, 32'h1234_5678, 1);
    do_data(1'b1, 2'd1, 32'h211, 32'h0000_FFFF, 1);
    do_fetch(32'h208, 3, 1'b1);
    do_fetch(32'h20C, 1, 1'b0);

    // Streak arbitration with both requests held, 3-cycle ack.
    model_cnt   = 0;
    bus.if_addr = FA;
    bus.d_we    = 1'b0;
    bus.d_size  = 2'd2;
    bus.d_addr  = DA;
    bus.d_wdata = 32'h5A5A_5A5A;
    bus.if_req  = 1'b1;
    bus.d_req   = 1'b1;
    ack_dly     = 3;
    collect(10, 3);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Reset in the middle of a data access that follows three data wins.
    model_cnt  = 0;
    ack_dly    = 1;
    bus.if_req = 1'b1;
    bus.d_req  = 1'b1;
    collect(3, 1);
    ack_dly = 10;
    n = 0;
    while (!bus.m_req && n < 10) begin @(posedge clk); #1; n++; end
    check("pre_reset_mreq", 32'(bus.m_req), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    @(posedge clk); #3 rst_n = 1'b1;
    ack_dly   = 1;
    model_cnt = 0;
    collect(5, 1);
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Randomized traffic against the reference memory.
    for (int t = 0; t < 48; t++) begin
      if ($urandom_range(0, 3) == 0)
        do_fetch({24'h0, 6'($urandom_range(0, 63)), 2'b00}, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      else
        do_data(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))},
                $urandom, int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port memory controller between instruction fetch (stage 1) and the memory-access stage (stage 4). The block arbitrates between the two requesters, converts stage-4 byte/half/word accesses into word-addressed memory transactions with byte enables, right-aligns returned load data, and reports misaligned data accesses. It sits between the pipeline stages and the memory controller and produces per-requester completion pulses that the pipeline uses to stall or advance.

## Interface
Parameters:
- MAX_D_STREAK, 4: consecutive data grants allowed while a fetch request waits; the next grant then goes to fetch.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr stable until if_valid.
- if_addr  in  32  fetch address; must be word aligned.
- if_rdata  out  32  fetched word; valid while if_valid=1.
- if_valid  out  1  one-cycle completion pulse for fetch.
- d_req  in  1  data request; held with all d_* inputs stable until d_valid.
- d_we  in  1  1=store, 0=load.
- d_size  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
- d_addr  in  32  byte address.
- d_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- d_rdata  out  32  load data, right-aligned, not extended; 0 for stores and errors.
- d_valid  out  1  one-cycle completion pulse for data.
- d_err  out  1  high together with d_valid when the data access was misaligned.
- m_req  out  1  memory request; held until m_ack.
- m_we  out  1  memory write.
- m_addr  out  32  word address ({addr[31:2],2'b00}).
- m_wdata  out  32  lane-replicated write data.
- m_be  out  4  byte enables.
- m_ack  in  1  memory accepted/completed the access; m_rdata is valid in the same cycle.
- m_rdata  in  32  memory read word.

## Operation
- FSM states: IDLE, ACC, RESP.
- IDLE: If there is no request, stay in IDLE. Otherwise, grant a requester, latch its address, data, size and write flag, and go to ACC.
  - Exception: a misaligned data grant goes directly to RESP with d_err set, and no memory access is made.
- Grant priority: data wins over fetch.
  - Streak counter: increments on each data grant made while if_req=1; clears on a fetch grant or when if_req=0.
  - When the counter equals MAX_D_STREAK and both requests are present, fetch is granted.
- Misaligned: a half access with addr[0]=1, or a word access with addr[1:0]≠0.
- ACC: m_req=1 with the latched fields. On m_ack, register the read data into the granted requester's rdata and go to RESP.
- RESP: pulse the granted requester's valid, then return to IDLE. Only one of if_valid and d_valid is ever high.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
  - fetch: 4'b1111
- m_wdata replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load alignment: d_rdata = m_rdata >> (8*addr[1:0]), then masked to 8, 16 or 32 bits.
- Fetch: m_we=0, and if_rdata=m_rdata.
- A request that drops during ACC still completes its memory access; the valid pulse is still issued.
- Reset (any time, including mid-access): go to IDLE and clear the streak counter. All outputs go to 0, including m_req, m_we, m_addr, m_wdata, m_be, if_rdata, d_rdata, if_valid, d_valid and d_err. An abandoned memory access is not retried.

## Timing
- Outputs are registered; nothing is combinational from input to output.
- Request sampled in IDLE at edge N:
  - m_req is high in cycle N+1.
  - If m_ack is high in cycle N+k (k≥1), valid is high in cycle N+k+1.
  - Minimum latency is 2 cycles; a zero-wait memory gives a throughput of one access per 3 cycles.
- Misaligned data: d_valid and d_err are high in cycle N+1.
- After a valid pulse, the requester must deassert or change its request in the following cycle. A request still high in IDLE is a new access.
- Simultaneous if_req and d_req in IDLE resolve by the priority and streak rules. The loser stays pending with no lost state.
- m_ack outside ACC is ignored.

## Test plan
- Fetch only, if_addr=0x100, m_rdata=0x00500093 with zero-wait ack -> m_req in cycle 1, m_be=4'hF, if_valid with if_rdata=0x00500093 in cycle 2.
- SB d_addr=0x203, d_wdata=0xAB -> m_addr=0x200, m_be=4'b1000, m_wdata=0xABABABAB, d_valid with d_rdata=0.
- LH d_addr=0x202, m_rdata=0x8001_1234 -> d_rdata=0x0000_8001. LBU d_addr=0x201 on the same word -> d_rdata=0x12.
- LW d_addr=0x206 -> d_valid and d_err one cycle after sampling, m_req never asserted.
- if_req and d_req held continuously, MAX_D_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F; m_ack delayed 3 cycles on every access -> valid 4 cycles after the grant edge.
- rst_n pulsed low during ACC -> all outputs 0 asynchronously; after release, a pending d_req is re-granted from IDLE and the streak count restarts at 0.
